// File: rtl/counter_pkg.sv
// Shared definitions for the counter control stage: FSM state encoding
// and default debounce/synchroniser depths.
package counter_pkg;

  // Encoding 2'd3 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Small default keeps simulation short; scale to ~10 ms of clk on silicon.
  localparam int DEBOUNCE_CYCLES_DEF = 50;
  localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser + debouncer + rising-edge detector for one raw board input.
// level is the accepted (debounced) level; rise_pulse is high for one cycle
// each time level goes from 0 to 1.
module btn_debounce
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   stable_prev_q;

  // Synchroniser chain; only the last stage feeds the debouncer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Count consecutive cycles the synced input differs from the accepted level;
  // any return to the accepted level restarts the count, so the counter never wraps.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = synced;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state and one-cycle-delayed copy of the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
    end
  end

  assign level      = stable_q;
  assign rise_pulse = stable_q & ~stable_prev_q;

endmodule

// File: rtl/counter_ctrl.sv
// Control stage for the 0-99 counter: conditions start/clear buttons and the
// direction switch, and runs the IDLE/RUN/PAUSE machine that gates divider
// ticks into count strobes.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_IDLE  | stopped; counter held, waiting for start
//   ST_RUN   | ticks are passed through as count_en strobes
//   ST_PAUSE | stopped mid-count; start resumes, clear returns to IDLE
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start_stop,
  input  logic btn_clear,
  input  logic sw_dir,
  input  logic tick_in,
  output logic count_en,
  output logic count_clr,
  output logic count_dir,
  output logic run
);

  logic   start_press;
  logic   clear_press;
  logic   start_level_unused;
  logic   clear_level_unused;
  logic   dir_level;
  logic   dir_rise_unused;

  state_e state_q, state_d;
  logic   count_en_q,  count_en_d;
  logic   count_clr_q, count_clr_d;
  logic   run_q,       run_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_db_start (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (btn_start_stop),
    .level      (start_level_unused),
    .rise_pulse (start_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_db_clear (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (btn_clear),
    .level      (clear_level_unused),
    .rise_pulse (clear_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_db_dir (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (sw_dir),
    .level      (dir_level),
    .rise_pulse (dir_rise_unused)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear has priority over start in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_press)      state_d = ST_IDLE;
        else if (start_press) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clear_press)      state_d = ST_IDLE;
        else if (start_press) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clear_press)      state_d = ST_IDLE;
        else if (start_press) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; count_en uses the pre-update state so a tick coinciding
  // with RUN->PAUSE still counts, and a clear press suppresses it so the two
  // strobes never overlap.
  always_comb begin
    count_en_d  = tick_in & (state_q == ST_RUN) & ~clear_press;
    count_clr_d = clear_press;
    run_d       = (state_d == ST_RUN);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
      run_q       <= run_d;
    end
  end

  assign count_en  = count_en_q;
  assign count_clr = count_clr_q;
  assign run       = run_q;
  // The debouncer's accepted-level flop is already a register; drive it out directly.
  assign count_dir = dir_level;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs change 1 time unit after a rising edge, so a value set there is first
// sampled by the next edge; an accepted press is visible inside the DUT after
// the 6th such edge and reaches run/count_clr after the 7th.
module tb_counter_ctrl;

  logic clk;
  logic rst_n;
  logic btn_start_stop;
  logic btn_clear;
  logic sw_dir;
  logic tick_in;
  logic count_en;
  logic count_clr;
  logic count_dir;
  logic run;

  int total  = 0;
  int passed = 0;

  counter_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .sw_dir         (sw_dir),
    .tick_in        (tick_in),
    .count_en       (count_en),
    .count_clr      (count_clr),
    .count_dir      (count_dir),
    .run            (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag, input logic en, input logic clr,
                            input logic dir, input logic rn);
    check({tag, ".count_en"},  count_en,  en);
    check({tag, ".count_clr"}, count_clr, clr);
    check({tag, ".count_dir"}, count_dir, dir);
    check({tag, ".run"},       run,       rn);
  endtask

  initial begin
    rst_n          = 1'b0;
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    sw_dir         = 1'b0;
    tick_in        = 1'b0;
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    rst_n = 1'b1;

    // Idle with periodic ticks: nothing moves.
    for (int i = 0; i < 20; i++) begin
      tick_in = (i % 5 == 0);
      step(1);
      tick_in = 1'b0;
      check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Bouncing start press, then held: run rises on the 7th edge after the final rise.
    btn_start_stop = 1'b1; step(1);
    btn_start_stop = 1'b0; step(1);
    btn_start_stop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("start_bounce.run", run, 1'b0);
    end
    step(1);
    check_outs("start_accept", 1'b0, 1'b0, 1'b0, 1'b1);

    // Ticks in RUN: each gives count_en exactly one cycle later, one cycle wide.
    for (int i = 0; i < 3; i++) begin
      step(2);
      tick_in = 1'b1;
      step(1);
      tick_in = 1'b0;
      check("run_tick.en", count_en, 1'b1);
      step(1);
      check("run_tick.en_drop", count_en, 1'b0);
    end

    // Release generates nothing.
    btn_start_stop = 1'b0;
    step(10);
    check_outs("start_release", 1'b0, 1'b0, 1'b0, 1'b1);

    // Second start press -> PAUSE; a tick in the deciding cycle still passes.
    btn_start_stop = 1'b1;
    step(6);
    check("pause_pre.run", run, 1'b1);
    tick_in = 1'b1;
    step(1);
    tick_in = 1'b0;
    check("pause.run", run, 1'b0);
    check("pause.tick_passed", count_en, 1'b1);
    step(1);
    check("pause.en_drop", count_en, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick_in = 1'b1;
      step(1);
      tick_in = 1'b0;
      check("pause_tick.en", count_en, 1'b0);
      step(2);
    end

    // Start and clear together in PAUSE: clear wins, back to IDLE.
    btn_start_stop = 1'b0;
    step(10);
    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    step(6);
    check("both_pre.clr", count_clr, 1'b0);
    step(1);
    check_outs("both_press", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    check_outs("both_after", 1'b0, 1'b0, 1'b0, 1'b0);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    step(10);
    check_outs("both_release", 1'b0, 1'b0, 1'b0, 1'b0);

    // Direction glitch of 3 cycles is rejected.
    sw_dir = 1'b1;
    step(3);
    sw_dir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("dir_glitch", count_dir, 1'b0);
    end

    // Direction held: accepted on the 6th edge.
    sw_dir = 1'b1;
    step(5);
    check("dir_hold.pre", count_dir, 1'b0);
    step(1);
    check("dir_hold.accept", count_dir, 1'b1);

    // Into RUN, then clear with a coincident tick: clear strobe only.
    btn_start_stop = 1'b1;
    step(7);
    check("run2.run", run, 1'b1);
    btn_start_stop = 1'b0;
    step(10);
    btn_clear = 1'b1;
    step(6);
    tick_in = 1'b1;
    step(1);
    tick_in = 1'b0;
    check_outs("clear_in_run", 1'b0, 1'b1, 1'b1, 1'b0);
    step(1);
    check("clear_in_run.clr_drop", count_clr, 1'b0);
    btn_clear = 1'b0;
    step(10);

    // Into RUN again, then async reset while the start debouncer is at count 2.
    btn_start_stop = 1'b1;
    step(7);
    check("run3.run", run, 1'b1);
    btn_start_stop = 1'b0;
    step(10);
    btn_start_stop = 1'b1;
    step(4);
    check("pre_reset.run", run, 1'b1);
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    btn_start_stop = 1'b0;
    sw_dir         = 1'b0;
    step(2);
    rst_n = 1'b1;
    tick_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick_in = 1'b0;

    // Button held through reset: debounce restarts from release.
    rst_n = 1'b0;
    btn_start_stop = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(6);
    check("held_through_reset.pre", run, 1'b0);
    step(1);
    check("held_through_reset.run", run, 1'b1);
    btn_start_stop = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
